// File: rtl/axil_pkg.sv
// axil_pkg: shared state encoding, response codes and timeout default for the AXI-Lite master
package axil_pkg;
  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_t;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int TO_CYC_DEF = 256;
endpackage

// File: rtl/axil_master_rw.sv
// axil_master_rw: single-beat AXI-Lite read/write master; AXIL_MASTER_TIMEOUT_EN adds a per-state timeout
module axil_master_rw
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_CYC = TO_CYC_DEF,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              start,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [STRB_W-1:0] strb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        resp,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp
);
  if (TO_CYC < 1) begin : g_bad_to
    $error("TO_CYC must be at least 1");
  end
  state_t r_state, w_state;
  logic r_go, w_go, r_rnw, w_rnw, r_busy, w_busy, r_done, w_done;
  logic r_awvalid, w_awvalid, r_wvalid, w_wvalid, r_bready, w_bready;
  logic r_arvalid, w_arvalid, r_rready, w_rready, r_aw_sent, w_aw_sent, r_w_sent, w_w_sent;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data, r_rdata, w_rdata;
  logic [STRB_W-1:0] r_strb, w_strb;
  logic [1:0] r_resp, w_resp;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] r_cnt, w_cnt;
`endif
  // Next-state and next-output logic; IDLE spends one cycle with r_go set before launching
  always_comb begin
    w_state = r_state;
    w_go = r_go;
    w_rnw = r_rnw;
    w_busy = r_busy;
    w_done = 1'b0;
    w_awvalid = r_awvalid;
    w_wvalid = r_wvalid;
    w_bready = r_bready;
    w_arvalid = r_arvalid;
    w_rready = r_rready;
    w_aw_sent = r_aw_sent;
    w_w_sent = r_w_sent;
    w_addr = r_addr;
    w_data = r_data;
    w_strb = r_strb;
    w_rdata = r_rdata;
    w_resp = r_resp;
    case (r_state)
      IDLE: begin
        if (r_go) begin
          w_go = 1'b0;
          w_state = r_rnw ? RADDR : WR;
          w_awvalid = ~r_rnw;
          w_wvalid = ~r_rnw;
          w_arvalid = r_rnw;
        end else if (start) begin
          w_go = 1'b1;
          w_busy = 1'b1;
          w_rnw = rnw;
          w_addr = addr;
          w_data = data;
          w_strb = strb;
        end
      end
      WR: begin
        w_aw_sent = r_aw_sent | (r_awvalid & awready);
        w_w_sent = r_w_sent | (r_wvalid & wready);
        w_awvalid = r_awvalid & ~awready;
        w_wvalid = r_wvalid & ~wready;
        if (w_aw_sent && w_w_sent) begin
          w_state = WRESP;
          w_bready = 1'b1;
          w_aw_sent = 1'b0;
          w_w_sent = 1'b0;
        end
      end
      WRESP: begin
        if (bvalid) begin
          w_state = IDLE;
          w_bready = 1'b0;
          w_resp = bresp;
          w_done = 1'b1;
          w_busy = 1'b0;
        end
      end
      RADDR: begin
        if (arready) begin
          w_state = RDATA;
          w_arvalid = 1'b0;
          w_rready = 1'b1;
        end
      end
      RDATA: begin
        if (rvalid) begin
          w_state = IDLE;
          w_rready = 1'b0;
          w_rdata = rdata_i;
          w_resp = rresp;
          w_done = 1'b1;
          w_busy = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
    w_cnt = (w_state != r_state) ? '0 : (r_state != IDLE) ? r_cnt + 1'b1 : r_cnt;
    if (r_state != IDLE && w_state == r_state && r_cnt == CW'(TO_CYC - 1)) begin
      w_state = IDLE;
      w_awvalid = 1'b0;
      w_wvalid = 1'b0;
      w_bready = 1'b0;
      w_arvalid = 1'b0;
      w_rready = 1'b0;
      w_aw_sent = 1'b0;
      w_w_sent = 1'b0;
      w_resp = SLVERR;
      w_done = 1'b1;
      w_busy = 1'b0;
      w_cnt = '0;
    end
`endif
  end
  // State and output registers, all cleared by synchronous reset
  always_ff @(posedge CLK) begin
    if (R) begin
      r_state <= IDLE;
      r_go <= 1'b0;
      r_rnw <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_bready <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready <= 1'b0;
      r_aw_sent <= 1'b0;
      r_w_sent <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_strb <= '0;
      r_rdata <= '0;
      r_resp <= OKAY;
`ifdef AXIL_MASTER_TIMEOUT_EN
      r_cnt <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_go <= w_go;
      r_rnw <= w_rnw;
      r_busy <= w_busy;
      r_done <= w_done;
      r_awvalid <= w_awvalid;
      r_wvalid <= w_wvalid;
      r_bready <= w_bready;
      r_arvalid <= w_arvalid;
      r_rready <= w_rready;
      r_aw_sent <= w_aw_sent;
      r_w_sent <= w_w_sent;
      r_addr <= w_addr;
      r_data <= w_data;
      r_strb <= w_strb;
      r_rdata <= w_rdata;
      r_resp <= w_resp;
`ifdef AXIL_MASTER_TIMEOUT_EN
      r_cnt <= w_cnt;
`endif
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign rdata = r_rdata;
  assign resp = r_resp;
  assign awvalid = r_awvalid;
  assign awaddr = r_addr;
  assign wvalid = r_wvalid;
  assign wdata = r_data;
  assign wstrb = r_strb;
  assign bready = r_bready;
  assign arvalid = r_arvalid;
  assign araddr = r_addr;
  assign rready = r_rready;
endmodule

// File: tb/tb_axil_master_rw.sv
// tb_axil_master_rw: directed self-checking bench for the AXI-Lite master
module tb_axil_master_rw;
  logic CLK = 1'b0, R = 1'b1;
  logic start = 1'b0, rnw = 1'b0;
  logic [31:0] addr = '0, data = '0, rdata, rdata_i = '0, wdata;
  logic [3:0] strb = '0, wstrb;
  logic busy, done, awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] resp, bresp = '0, rresp = '0;
  logic [31:0] awaddr, araddr;
  int n_cmp = 0, n_bad = 0;
  axil_master_rw #(.ADDR_W(32), .DATA_W(32), .TO_CYC(8)) dut (
    .CLK(CLK), .R(R), .start(start), .rnw(rnw), .addr(addr), .data(data), .strb(strb),
    .busy(busy), .done(done), .rdata(rdata), .resp(resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata_i(rdata_i), .rresp(rresp)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(negedge CLK);
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    start = 1'b1; rnw = r; addr = a; data = d; strb = s;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valids", {awvalid, wvalid, arvalid}, 0);
    check("rst_readies", {bready, rready}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp", resp, 0);
    check("rst_addr", awaddr, 0);
    R = 1'b0;
    tick();
    // write with every ready high: done in cycle 4
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    go(0, 32'h10, 32'hDEADBEEF, 4'hF);
    check("w1_busy", busy, 1);
    check("w1_aw_early", awvalid, 0);
    tick();
    check("w1_valids", {awvalid, wvalid}, 2'b11);
    check("w1_awaddr", awaddr, 32'h10);
    check("w1_wdata", wdata, 32'hDEADBEEF);
    check("w1_wstrb", wstrb, 4'hF);
    tick();
    check("w1_wresp", {awvalid, wvalid, bready, done}, 4'b0010);
    tick();
    check("w1_done", {done, busy}, 2'b10);
    check("w1_resp", resp, 2'b00);
    tick();
    check("w1_done_pulse", done, 0);
    // W handshake three cycles after AW
    wready = 0; bvalid = 0;
    go(0, 32'h44, 32'hA5A50001, 4'h3);
    tick();
    check("w2_valids", {awvalid, wvalid}, 2'b11);
    tick();
    check("w2_aw_drop", {awvalid, wvalid}, 2'b01);
    tick();
    check("w2_w_hold", {wvalid, wdata}, {1'b1, 32'hA5A50001});
    tick();
    check("w2_w_hold2", {wvalid, wdata, wstrb}, {1'b1, 32'hA5A50001, 4'h3});
    wready = 1;
    tick();
    check("w2_wresp", {wvalid, bready, done}, 3'b010);
    bvalid = 1; bresp = 2'b10;
    tick();
    check("w2_done", {done, resp}, 3'b110);
    bvalid = 0;
    tick();
    check("w2_single_done", {done, bready, busy}, 0);
    // read, then a write must not disturb rdata
    arready = 1; rvalid = 1; rdata_i = 32'h12345678; rresp = 2'b00;
    go(1, 32'h20, 32'h0, 4'h0);
    tick();
    check("r1_arvalid", {arvalid, araddr}, {1'b1, 32'h20});
    tick();
    check("r1_rready", {arvalid, rready, done}, 3'b010);
    tick();
    check("r1_done", {done, busy, resp}, 4'b1000);
    check("r1_rdata", rdata, 32'h12345678);
    rvalid = 0; rdata_i = 32'hFFFF0000;
    tick();
    check("r1_done_pulse", done, 0);
    bvalid = 1; bresp = 2'b00;
    go(0, 32'h28, 32'h0BADF00D, 4'hF);
    repeat (3) tick();
    check("r1w_done", done, 1);
    check("r1_rdata_kept", rdata, 32'h12345678);
    // start during WRESP is ignored
    bvalid = 0;
    go(0, 32'h30, 32'h11112222, 4'h1);
    repeat (2) tick();
    check("w3_wresp", bready, 1);
    start = 1; rnw = 1; addr = 32'h99;
    tick();
    start = 0; bvalid = 1;
    tick();
    check("w3_done", done, 1);
    bvalid = 0;
    seen = 0;
    repeat (5) begin
      tick();
      seen = seen | busy | arvalid | awvalid | done;
    end
    check("w3_no_second", seen, 0);
    check("w3_addr_kept", awaddr, 32'h30);
    // reset while waiting in RDATA
    arready = 1; rvalid = 0;
    go(1, 32'h40, 32'h0, 4'h0);
    repeat (2) tick();
    check("r2_rready", rready, 1);
    R = 1;
    tick();
    R = 0;
    check("r2_rst_outs", {busy, done, rready, arvalid, awvalid, wvalid, bready}, 0);
    check("r2_rst_data", {rdata, resp, araddr}, 0);
    rvalid = 1;
    tick();
    check("r2_no_done", {done, busy}, 0);
    rdata_i = 32'hCAFEF00D;
    go(1, 32'h24, 32'h0, 4'h0);
    repeat (3) tick();
    check("r3_done", done, 1);
    check("r3_rdata", rdata, 32'hCAFEF00D);
    rvalid = 0;
`ifdef AXIL_MASTER_TIMEOUT_EN
    arready = 0;
    tick();
    go(1, 32'h50, 32'h0, 4'h0);
    tick();
    check("to_arvalid", arvalid, 1);
    repeat (7) tick();
    check("to_still_waiting", {arvalid, done}, 2'b10);
    tick();
    check("to_fire", {arvalid, rready, done, busy}, 4'b0010);
    check("to_resp", resp, 2'b10);
    tick();
    check("to_pulse", done, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axil_master_rw.md
AXIL_MASTER_RW -- requirements
Module: axil_master_rw

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width (8, 16, 32 or 64); STRB_W = DATA_W/8 is derived.
REQ-003 SHALL have parameter TO_CYC, default 256, timeout limit in cycles; used only when the timeout feature is compiled in.
REQ-004 SHALL have ports, clock and reset first: CLK in 1, sole clock; R in 1, reset, synchronous, active-high.
REQ-005 SHALL have command ports: start in 1; rnw in 1 (1 = read); addr in ADDR_W; data in DATA_W; strb in STRB_W; busy out 1; done out 1; rdata out DATA_W; resp out 2.
REQ-006 SHALL have write address channel: awvalid out 1; awready in 1; awaddr out ADDR_W.
REQ-007 SHALL have write data channel: wvalid out 1; wready in 1; wdata out DATA_W; wstrb out STRB_W.
REQ-008 SHALL have write response channel: bvalid in 1; bready out 1; bresp in 2.
REQ-009 SHALL have read channels: arvalid out 1; arready in 1; araddr out ADDR_W; rvalid in 1; rready out 1; rdata_i in DATA_W; rresp in 2.
REQ-010 SHALL register every output.

Function
REQ-011 SHALL implement states IDLE, WR (AW and W in flight), WRESP, RADDR, RDATA.
REQ-012 In IDLE with start=1, SHALL latch addr, data and strb, assert busy, and on the next cycle enter WR (rnw=0) or RADDR (rnw=1).
REQ-013 start while busy=1 SHALL be ignored; no queuing.
REQ-014 In WR, SHALL assert awvalid and wvalid together, each held until its own handshake (valid && ready).
REQ-015 Handshakes in WR SHALL be accepted in any order or in the same cycle; each valid drops the cycle after its handshake, tracked by two sent flags.
REQ-016 When both AW and W have handshaked, SHALL assert bready and enter WRESP.
REQ-017 In WRESP on bvalid, SHALL drop bready, capture bresp into resp, pulse done for 1 cycle, and return to IDLE.
REQ-018 In RADDR, SHALL assert arvalid until arready; then drop arvalid, assert rready, and enter RDATA.
REQ-019 In RDATA on rvalid, SHALL drop rready, capture rdata_i into rdata and rresp into resp, pulse done, and return to IDLE.
REQ-020 busy SHALL deassert in the same cycle done pulses; the next start is accepted in the cycle after done.
REQ-021 Once asserted, a valid SHALL NOT drop and its payload SHALL NOT change before its handshake.
REQ-022 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter rdata.
REQ-023 Minimum latency with ready signals tied high SHALL be 4 cycles from start to done, for both write and read.

Reset
REQ-024 R=1 at a CLK edge SHALL force IDLE; clear all valid and ready outputs, busy, done, rdata, resp, addresses, data, strobes, sent flags and timeout counter to 0.
REQ-025 R asserted mid-transaction SHALL abandon it with no done pulse; an in-flight handshake is not completed.

Configuration
REQ-026 Macro AXIL_MASTER_TIMEOUT_EN defined: a counter SHALL clear on each state entry and increment every cycle in a non-IDLE state.
REQ-027 With the macro, reaching TO_CYC cycles SHALL drop all valid and ready outputs, set resp=2'b10, pulse done, and return to IDLE.
REQ-028 With the macro undefined, there SHALL be no counter logic and waits are unbounded.

Structure
REQ-029 Package axil_pkg SHALL hold the state enum, response codes OKAY=2'b00 and SLVERR=2'b10, and the TO_CYC default.
REQ-030 No sub-module; single flat module.

Verification
REQ-031 Write, ready signals high: start, addr=0x10, data=0xDEADBEEF, strb=0xF -> awaddr=0x10, wdata=0xDEADBEEF, done at cycle 4, resp=0.
REQ-032 wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held stable, single done, resp=bresp.
REQ-033 Read addr=0x20, rdata_i=0x12345678, rresp=2'b00 -> rdata=0x12345678, done pulse of 1 cycle, rdata stable through a following write.
REQ-034 start pulsed during WRESP -> ignored; exactly one transaction seen on the bus.
REQ-035 R asserted in RDATA -> all outputs 0 next cycle, no done, next start works normally.
REQ-036 Timeout macro on, TO_CYC=8, arready held 0 -> after 8 cycles arvalid=0, resp=2'b10, done pulses.
